// File: rtl/matrix_calc_pkg.sv
// Shared definitions for the matrix calculator: FSM state codes,
// one-hot operation codes and the countdown state encoding.
package matrix_calc_pkg;

   localparam logic [3:0] S0_IDLE   = 4'd0;
   localparam logic [3:0] S8_SELECT = 4'd8;
   localparam logic [3:0] S9_WAIT   = 4'd9;

   localparam logic [3:0] OP_T = 4'b0001;
   localparam logic [3:0] OP_A = 4'b0010;
   localparam logic [3:0] OP_B = 4'b0100;
   localparam logic [3:0] OP_C = 4'b1000;

   typedef enum logic [1:0] {
      CD_IDLE = 2'd0,
      CD_RUN  = 2'd1,
      CD_HOLD = 2'd2,
      CD_DONE = 2'd3
   } cd_state_e;

   function automatic logic is_onehot4(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability-count debounce
// and a registered one-cycle strobe on the debounced rising edge.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   output logic press
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          db_q;
   logic          db_d;
   logic          dbp_q;
   logic          press_q;
   logic          press_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      db_d    = db_q;
      cnt_d   = '0;
      press_d = db_q & ~dbp_q;
      // level flips only once it has disagreed for the full window
      if (sync2_q != db_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            db_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         db_q    <= 1'b0;
         dbp_q   <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= btn_in;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         dbp_q   <= db_q;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/op_select_input.sv
// Front-panel operation selector: latches confirmed one-hot op codes
// and runs the WAIT-state seconds countdown for the display and FSM.
module op_select_input
   import matrix_calc_pkg::*;
#(
   parameter int unsigned CLK_HZ          = 100_000_000,
   parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
   parameter int unsigned WAIT_SEC        = 9
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] state,
   input  logic [3:0] sw_op,
   input  logic       btn_confirm,
   output logic [3:0] op_type,
   output logic       op_valid,
   output logic       op_confirm,
   output logic       op_error,
   output logic       timeout,
   output logic [3:0] sec_left
);

   localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

   logic [3:0]    sw_s1_q;
   logic [3:0]    sw_s2_q;
   logic          press;
   logic          in_s9;
   logic          acc;
   logic          valid_acc;
   logic          tick;
   logic          run_now;
   cd_state_e     cd_q;
   cd_state_e     cd_d;
   logic [PW-1:0] presc_q;
   logic [PW-1:0] presc_d;
   logic [3:0]    sec_q;
   logic [3:0]    sec_d;
   logic [3:0]    op_type_q;
   logic [3:0]    op_type_d;
   logic          op_valid_q;
   logic          op_valid_d;
   logic          op_confirm_q;
   logic          op_confirm_d;
   logic          op_error_q;
   logic          op_error_d;
   logic          timeout_q;
   logic          timeout_d;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn_confirm (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_in(btn_confirm),
      .press (press)
   );

   always_comb begin
      in_s9     = (state == S9_WAIT);
      acc       = press && ((state == S8_SELECT) || in_s9);
      valid_acc = acc && is_onehot4(sw_s2_q);
      tick      = (presc_q == PW'(CLK_HZ - 1));
      run_now   = in_s9 && ((cd_q == CD_IDLE) || (cd_q == CD_RUN));

      op_type_d    = op_type_q;
      op_valid_d   = op_valid_q;
      op_confirm_d = valid_acc;
      op_error_d   = acc && !is_onehot4(sw_s2_q);
      if (state == S0_IDLE) begin
         op_type_d  = 4'd0;
         op_valid_d = 1'b0;
      end else if (valid_acc) begin
         op_type_d  = sw_s2_q;
         op_valid_d = 1'b1;
      end

      cd_d      = cd_q;
      presc_d   = presc_q;
      sec_d     = sec_q;
      timeout_d = 1'b0;
      // the first S9 cycle already counts as a prescaler step
      if (!in_s9) begin
         cd_d    = CD_IDLE;
         presc_d = '0;
         sec_d   = 4'(WAIT_SEC);
      end else if (run_now) begin
         if (valid_acc) begin
            cd_d = CD_HOLD;
         end else if (tick) begin
            presc_d = '0;
            sec_d   = sec_q - 4'd1;
            if (sec_q == 4'd1) begin
               timeout_d = 1'b1;
               cd_d      = CD_DONE;
            end else begin
               cd_d = CD_RUN;
            end
         end else begin
            presc_d = presc_q + 1'b1;
            cd_d    = CD_RUN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sw_s1_q      <= 4'd0;
         sw_s2_q      <= 4'd0;
         cd_q         <= CD_IDLE;
         presc_q      <= '0;
         sec_q        <= 4'(WAIT_SEC);
         op_type_q    <= 4'd0;
         op_valid_q   <= 1'b0;
         op_confirm_q <= 1'b0;
         op_error_q   <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         sw_s1_q      <= sw_op;
         sw_s2_q      <= sw_s1_q;
         cd_q         <= cd_d;
         presc_q      <= presc_d;
         sec_q        <= sec_d;
         op_type_q    <= op_type_d;
         op_valid_q   <= op_valid_d;
         op_confirm_q <= op_confirm_d;
         op_error_q   <= op_error_d;
         timeout_q    <= timeout_d;
      end
   end

   assign op_type    = op_type_q;
   assign op_valid   = op_valid_q;
   assign op_confirm = op_confirm_q;
   assign op_error   = op_error_q;
   assign timeout    = timeout_q;
   assign sec_left   = sec_q;

endmodule

// File: tb/tb_op_select_input.sv
// Scoreboard bench for op_select_input: expected pulses are queued
// with their due cycle when stimulus is driven.
module tb_op_select_input;

   typedef struct {
      int         kind;
      int         cyc;
      logic [3:0] op;
      logic [3:0] sec;
   } ev_t;

   localparam int K_CONF = 0;
   localparam int K_ERR  = 1;
   localparam int K_TO   = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] state;
   logic [3:0] sw_op;
   logic       btn;
   logic [3:0] op_type;
   logic       op_valid;
   logic       op_confirm;
   logic       op_error;
   logic       timeout;
   logic [3:0] sec_left;

   int  total = 0;
   int  bad = 0;
   int  cyc = 0;
   int  npulse = 0;
   ev_t q[$];

   op_select_input #(
      .CLK_HZ         (10),
      .DEBOUNCE_CYCLES(4),
      .WAIT_SEC       (9)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .state      (state),
      .sw_op      (sw_op),
      .btn_confirm(btn),
      .op_type    (op_type),
      .op_valid   (op_valid),
      .op_confirm (op_confirm),
      .op_error   (op_error),
      .timeout    (timeout),
      .sec_left   (sec_left)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   task automatic exp_ev(input int k, input int c, input logic [3:0] o,
                         input logic [3:0] s);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      e.op   = o;
      e.sec  = s;
      q.push_back(e);
   endtask

   task automatic ev(input int k);
      ev_t e;
      npulse++;
      chk("sb_nonempty", q.size() != 0, 1);
      if (q.size() != 0) begin
         e = q.pop_front();
         chk("ev_kind", k, e.kind);
         chk("ev_cyc", cyc, e.cyc);
         chk("ev_op", op_type, e.op);
         chk("ev_sec", sec_left, e.sec);
      end
   endtask

   always @(negedge clk) begin
      if (op_confirm) ev(K_CONF);
      if (op_error) ev(K_ERR);
      if (timeout) ev(K_TO);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic to_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic bounce();
      for (int i = 0; i < 10; i++) begin
         btn = (i % 2 == 0);
         tick(2);
      end
      btn = 1'b1;
   endtask

   initial begin
      int n0;
      int p0;
      logic [3:0] es;
      rst_n = 1'b0;
      state = 4'd0;
      sw_op = 4'd0;
      btn   = 1'b0;
      tick(3);
      chk("rst_op_type", op_type, 0);
      chk("rst_op_valid", op_valid, 0);
      chk("rst_confirm", op_confirm, 0);
      chk("rst_error", op_error, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_sec", sec_left, 9);
      rst_n = 1'b1;
      p0 = npulse;
      tick(100);
      chk("quiet_pulses", npulse - p0, 0);

      // press outside the accept window
      state = 4'd4;
      sw_op = 4'b0001;
      tick(3);
      btn = 1'b1;
      tick(15);
      btn = 1'b0;
      tick(10);
      chk("win_pulses", npulse - p0, 0);
      chk("win_valid", op_valid, 0);

      // clean valid press in SELECT
      state = 4'd8;
      sw_op = 4'b0100;
      tick(3);
      btn = 1'b1;
      exp_ev(K_CONF, cyc + 8, 4'b0100, 4'd9);
      tick(12);
      chk("t2_op_type", op_type, 4'b0100);
      chk("t2_op_valid", op_valid, 1);
      btn = 1'b0;
      tick(10);

      // bouncy valid press, then bouncy invalid press
      sw_op = 4'b0001;
      tick(3);
      bounce();
      exp_ev(K_CONF, cyc + 8, 4'b0001, 4'd9);
      tick(15);
      btn = 1'b0;
      tick(10);
      chk("t3_op_type", op_type, 4'b0001);
      sw_op = 4'b0110;
      tick(3);
      bounce();
      exp_ev(K_ERR, cyc + 8, 4'b0001, 4'd9);
      tick(15);
      btn = 1'b0;
      tick(10);
      chk("t3_err_op_type", op_type, 4'b0001);
      chk("t3_err_valid", op_valid, 1);
      chk("t3_drain", q.size(), 0);

      // free-running countdown to timeout
      state = 4'd9;
      n0 = cyc;
      exp_ev(K_TO, n0 + 90, 4'b0001, 4'd0);
      for (int n = 1; n <= 140; n++) begin
         tick(1);
         es = (n >= 90) ? 4'd0 : 4'(9 - n / 10);
         chk("t4_sec", sec_left, es);
      end
      chk("t4_drain", q.size(), 0);
      state = 4'd8;
      sw_op = 4'b0010;
      tick(3);

      // confirm at cycle 35 freezes the count
      state = 4'd9;
      n0 = cyc;
      to_cyc(n0 + 27);
      btn = 1'b1;
      exp_ev(K_CONF, n0 + 35, 4'b0010, 4'd6);
      to_cyc(n0 + 45);
      btn = 1'b0;
      to_cyc(n0 + 110);
      chk("t5a_sec", sec_left, 6);
      chk("t5a_drain", q.size(), 0);

      // confirm colliding with the final wrap wins
      state = 4'd8;
      sw_op = 4'b0100;
      tick(3);
      state = 4'd9;
      n0 = cyc;
      to_cyc(n0 + 82);
      btn = 1'b1;
      exp_ev(K_CONF, n0 + 90, 4'b0100, 4'd1);
      to_cyc(n0 + 95);
      btn = 1'b0;
      to_cyc(n0 + 120);
      chk("t5b_sec", sec_left, 1);
      chk("t5b_drain", q.size(), 0);

      // leaving S9 mid-count reloads and restarts
      state = 4'd8;
      tick(2);
      state = 4'd9;
      n0 = cyc;
      to_cyc(n0 + 35);
      chk("t6_mid_sec", sec_left, 6);
      state = 4'd4;
      tick(1);
      state = 4'd9;
      n0 = cyc;
      exp_ev(K_TO, n0 + 90, 4'b0100, 4'd0);
      tick(1);
      chk("t6_reload", sec_left, 9);
      to_cyc(n0 + 10);
      chk("t6_restart", sec_left, 8);
      to_cyc(n0 + 95);
      chk("t6_drain", q.size(), 0);
      state = 4'd0;
      tick(1);
      chk("t6_clr_valid", op_valid, 0);
      chk("t6_clr_type", op_type, 0);

      // reset at cycle 45 abandons the count
      state = 4'd9;
      n0 = cyc;
      to_cyc(n0 + 45);
      chk("t6_pre_rst_sec", sec_left, 5);
      rst_n = 1'b0;
      state = 4'd0;
      tick(2);
      chk("t6_rst_sec", sec_left, 9);
      chk("t6_rst_timeout", timeout, 0);
      rst_n = 1'b1;
      p0 = npulse;
      tick(100);
      chk("t6_rst_quiet", npulse - p0, 0);
      chk("sb_drain", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
